// File: rtl/cascade_time_counter_pkg.sv
// Shared types and helpers for the cascaded modulo counter (seconds/minutes/hours style).
package def;

    localparam int STAGE_W = 8;

    typedef enum logic [1:0] {
        WRAP    = 2'd0,
        ONESHOT = 2'd1,
        PAUSE   = 2'd2
    } cnt_mode_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cascade_time_counter_if.sv
// Setup/count/status bundle between the prescaler/setup logic (master) and the counter chain (slave).
interface cascade_time_counter_if #(
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = def::clog2_min1(NUM_STAGES)
);
    import def::*;

    // No handshake: clr, load and tick are single-cycle strobes sampled on every rising
    // clock edge with no back-pressure; status pulses are valid for exactly one cycle.
    logic                          clr;
    logic                          load;
    logic [SEL_W-1:0]              setup_sel;
    logic [STAGE_W-1:0]            setup_data;
    logic                          tick;
    logic                          up_down;
    cnt_mode_t                     mode;
    logic [STAGE_W*NUM_STAGES-1:0] alarm_val;
    logic [STAGE_W*NUM_STAGES-1:0] value;
    logic [NUM_STAGES-1:0]         stage_carry;
    logic                          rollover;
    logic                          done;
    logic                          load_err;
    logic                          alarm_hit;

    modport master (
        output clr, load, setup_sel, setup_data, tick, up_down, mode, alarm_val,
        input  value, stage_carry, rollover, done, load_err, alarm_hit
    );

    modport slave (
        input  clr, load, setup_sel, setup_data, tick, up_down, mode, alarm_val,
        output value, stage_carry, rollover, done, load_err, alarm_hit
    );

endinterface

// File: rtl/cascade_time_counter_mod_stage.sv
// One modulo-MOD stage: combinational next value and carry/borrow-out.
module mod_stage
    import def::*;
#(
    parameter int MOD = 60
) (
    input  logic [STAGE_W-1:0] cur,
    input  logic               cin,
    input  logic               up,
    output logic [STAGE_W-1:0] nxt,
    output logic               cout
);

    localparam logic [STAGE_W-1:0] MAX = STAGE_W'(MOD - 1);

    always_comb begin
        nxt  = cur;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (cur == MAX) begin
                    nxt  = '0;
                    cout = 1'b1;
                end else begin
                    nxt = cur + 1'b1;
                end
            end else begin
                if (cur == '0) begin
                    nxt  = MAX;
                    cout = 1'b1;
                end else begin
                    nxt = cur - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cascade_time_counter.sv
// Cascaded modulo counter chain with per-stage load, wrap/one-shot/pause modes.
// Optional alarm compare is built when CNT_ALARM_EN is defined.
module cascade_time_counter
    import def::*;
#(
    parameter int NUM_STAGES        = 3,
    parameter int MODS [NUM_STAGES] = '{60, 60, 24},
    parameter int SEL_W             = clog2_min1(NUM_STAGES)
) (
    input logic                   clock,
    input logic                   reset,
    cascade_time_counter_if.slave bus
);

    localparam int W = STAGE_W * NUM_STAGES;

    logic [W-1:0]          value_q, value_n, nxt_word;
    logic [NUM_STAGES-1:0] carry_q, carry_n;
    logic [NUM_STAGES:0]   chain;
    logic                  roll_q, roll_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;
    logic                  alarm_q, alarm_n;
    logic                  load_ok;
    logic                  tick_upd;

    assign chain[0] = 1'b1;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        mod_stage #(.MOD(MODS[g])) u_stage (
            .cur  (value_q[STAGE_W*g +: STAGE_W]),
            .cin  (chain[g]),
            .up   (bus.up_down),
            .nxt  (nxt_word[STAGE_W*g +: STAGE_W]),
            .cout (chain[g+1])
        );
    end

    always_comb begin
        value_n  = value_q;
        carry_n  = '0;
        roll_n   = 1'b0;
        done_n   = done_q;
        err_n    = 1'b0;
        alarm_n  = 1'b0;
        load_ok  = 1'b0;
        tick_upd = 1'b0;

        for (int i = 0; i < NUM_STAGES; i++) begin
            if (bus.setup_sel == SEL_W'(i) && {1'b0, bus.setup_data} < 9'(MODS[i]))
                load_ok = 1'b1;
        end

        if (bus.clr) begin
            value_n = '0;
            done_n  = 1'b0;
        end else if (bus.load) begin
            if (load_ok) begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    if (bus.setup_sel == SEL_W'(i))
                        value_n[STAGE_W*i +: STAGE_W] = bus.setup_data;
                end
                done_n = 1'b0;
            end else begin
                err_n = 1'b1;
            end
        end else if (bus.tick) begin
            case (bus.mode)
                WRAP: begin
                    value_n  = nxt_word;
                    carry_n  = chain[NUM_STAGES:1];
                    roll_n   = chain[NUM_STAGES];
                    tick_upd = 1'b1;
                end
                ONESHOT: begin
                    // The terminal tick freezes the chain instead of wrapping.
                    if (!done_q) begin
                        if (chain[NUM_STAGES]) begin
                            done_n = 1'b1;
                        end else begin
                            value_n  = nxt_word;
                            carry_n  = chain[NUM_STAGES:1];
                            tick_upd = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (bus.mode != ONESHOT)
            done_n = 1'b0;

`ifdef CNT_ALARM_EN
        alarm_n = tick_upd && (value_n == bus.alarm_val);
`endif
    end

`ifndef CNT_ALARM_EN
    logic unused_alarm;
    assign unused_alarm = ^{bus.alarm_val, tick_upd};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
            carry_q <= '0;
            roll_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            value_q <= value_n;
            carry_q <= carry_n;
            roll_q  <= roll_n;
            done_q  <= done_n;
            err_q   <= err_n;
            alarm_q <= alarm_n;
        end
    end

    assign bus.value       = value_q;
    assign bus.stage_carry = carry_q;
    assign bus.rollover    = roll_q;
    assign bus.done        = done_q;
    assign bus.load_err    = err_q;
    assign bus.alarm_hit   = alarm_q;

endmodule
